// File: rtl/prefix_adder5_pkg.sv
// Shared constants for the prefix adder slice.
package prefix_adder5_pkg;
  localparam int PA_WIDTH = 5;
endpackage

// File: rtl/prefix_adder5_cells.sv
// Leaf cells of the prefix tree: per-bit generate/propagate (A) and span combine (B).
module prefix_gp_cell (
  input  logic x,
  input  logic y,
  output logic e,
  output logic g,
  output logic p
);
  assign e = x ^ y;
  assign g = x & y;
  assign p = x ^ y;
endmodule

module prefix_combine_cell (
  input  logic g2,
  input  logic p2,
  input  logic g1,
  input  logic p1,
  output logic g,
  output logic p
);
  assign g = g2 | (p2 & g1);
  assign p = p2 & p1;
endmodule

// File: rtl/prefix_adder5.sv
// Registered parallel-prefix adder: {cout,z} <= x + y one cycle after in_valid.
module prefix_adder5
  import prefix_adder5_pkg::*;
#(
  parameter int WIDTH = PA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             out_valid
);
  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;

  logic [WIDTH-1:0] e, g0, p0;
  logic [WIDTH-1:0] z_nxt;
  logic             cout_nxt;
  logic             unused_p;

  for (genvar i = 0; i < WIDTH; i++) begin : gp
    prefix_gp_cell u_gp (.x(x[i]), .y(y[i]), .e(e[i]), .g(g0[i]), .p(p0[i]));
  end

  // Sklansky tree: at level l, bit i with bit (l-1) set absorbs the group ending
  // just below its 2^(l-1)-aligned boundary, so lvl[LEVELS].g[i] = G[i:0].
  for (genvar l = 0; l <= LEVELS; l++) begin : lvl
    logic [WIDTH-1:0] g, p;
    if (l == 0) begin : base
      assign g = g0;
      assign p = p0;
    end else begin : comb
      for (genvar i = 0; i < WIDTH; i++) begin : bit_
        if (((i >> (l-1)) & 1) == 1) begin : node
          localparam int J = ((i >> (l-1)) << (l-1)) - 1;
          prefix_combine_cell u_b (
            .g2(lvl[l-1].g[i]), .p2(lvl[l-1].p[i]),
            .g1(lvl[l-1].g[J]), .p1(lvl[l-1].p[J]),
            .g (g[i]),          .p (p[i])
          );
        end else begin : pass
          assign g[i] = lvl[l-1].g[i];
          assign p[i] = lvl[l-1].p[i];
        end
      end
    end
  end

  // Final-level group propagates are not needed without a carry-in.
  assign unused_p = ^lvl[LEVELS].p;

  always_comb begin
    z_nxt    = e;
    for (int i = 1; i < WIDTH; i++)
      z_nxt[i] = e[i] ^ lvl[LEVELS].g[i-1];
    cout_nxt = lvl[LEVELS].g[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        z    <= z_nxt;
        cout <= cout_nxt;
      end
    end
  end
endmodule

// File: tb/tb_prefix_adder5.sv
// Directed and exhaustive checks of prefix_adder5 against hand-computed sums.
module tb_prefix_adder5;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] x, y, z;
  logic         cout, out_valid;
  int           passed = 0;
  int           total  = 0;

  always #5 clk = ~clk;

  prefix_adder5 #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y),
    .z(z), .cout(cout), .out_valid(out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic apply(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = v; x = a; y = b;
    @(posedge clk);
    #1;
  endtask

  task automatic sum(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ez, input logic ec);
    apply(1'b1, a, b);
    chk({tag, ".z"}, 32'(z), 32'(ez));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".vld"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [W:0] e;
    rst_n = 1'b1; in_valid = 1'b1; x = 5'd3; y = 5'd3;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.z", 32'(z), 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.vld", 32'(out_valid), 32'd0);

    // First edge after release samples 3+3 normally.
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel.z", 32'(z), 32'd6);
    chk("rel.vld", 32'(out_valid), 32'd1);

    sum("b0", 5'b00000, 5'b00000, 5'b00000, 1'b0);
    sum("b1", 5'b00001, 5'b00001, 5'b00010, 1'b0);
    sum("b2", 5'b00101, 5'b00011, 5'b01000, 1'b0);
    sum("b3", 5'b01100, 5'b00101, 5'b10001, 1'b0);

    apply(1'b0, 5'b11111, 5'b00001);
    chk("hold1.vld", 32'(out_valid), 32'd0);
    chk("hold1.z", 32'(z), 32'b10001);
    chk("hold1.cout", 32'(cout), 32'd0);
    apply(1'b0, 5'b10101, 5'b01011);
    chk("hold2.vld", 32'(out_valid), 32'd0);
    chk("hold2.z", 32'(z), 32'b10001);

    sum("w0", 5'b10101, 5'b01011, 5'b00000, 1'b1);
    sum("w1", 5'b11111, 5'b11111, 5'b11110, 1'b1);
    sum("w2", 5'b11100, 5'b01010, 5'b00110, 1'b1);

    // Asynchronous assertion mid-cycle, no clock edge in between.
    #2 rst_n = 1'b0;
    #1;
    chk("arst.z", 32'(z), 32'd0);
    chk("arst.cout", 32'(cout), 32'd0);
    chk("arst.vld", 32'(out_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++) begin
        apply(1'b1, W'(a), W'(b));
        e = 6'(a + b);
        chk($sformatf("exh_%0d_%0d", a, b), 32'({cout, z}), 32'(e));
        chk("exh.vld", 32'(out_valid), 32'd1);
      end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
